// File: rtl/mmio_reg_arbiter_pkg.sv
// Shared encodings for the MMIO register-bank arbiter: FSM states, grant IDs, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mmio_arb_pkg;

    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_ADDR_W   = 2;
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_UART = 1'b1;

endpackage

// File: rtl/mmio_reg_arbiter_rr.sv
// Two-way round-robin grant picker: a lone requester wins, a tie goes to the one not granted last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken and owns last_grant.
//
// Ports: req[0]=CPU, req[1]=UART; last_grant is the previous winner; grant_id is valid with grant_valid.
module rr_arbiter_2
    import mmio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        if (&req) begin
            grant_id = ~last_grant;
        end else begin
            // Only one (or no) requester: the UART bit alone decides the index.
            grant_id = req[1] ? GNT_UART : GNT_CPU;
        end
    end

endmodule

// File: rtl/mmio_reg_arbiter.sv
// Arbitrates CPU and UART accesses onto a shared bank of tri-state MMIO registers with one-hot strobes.
// Latency: write ack at IDLE+1, read ack at IDLE+2 (one dead TURN cycle always follows an access).
// Backpressure: requesters hold req until ack; the loser of arbitration simply waits for the next IDLE.
//
// Ports: clock/reset (async, active low); cpu_* and uart_* level req/we/addr/wdata in, ack pulse and
// held rdata out; reg_enable/reg_oe one-hot strobes, reg_d shared write data, reg_q shared read bus.
// Build option MMIO_ARB_ERR_EN adds cpu_err/uart_err and the RO_MASK parameter (read-only registers).
module mmio_reg_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
`ifdef MMIO_ARB_ERR_EN
    ,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
`endif
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                uart_req,
    input  logic                uart_we,
    input  logic [ADDR_W-1:0]   uart_addr,
    input  logic [DATA_W-1:0]   uart_wdata,
    output logic                uart_ack,
    output logic [DATA_W-1:0]   uart_rdata,
`ifdef MMIO_ARB_ERR_EN
    output logic                cpu_err,
    output logic                uart_err,
`endif
    output logic [NUM_REGS-1:0] reg_enable,
    output logic [NUM_REGS-1:0] reg_oe,
    output logic [DATA_W-1:0]   reg_d,
    input  logic [DATA_W-1:0]   reg_q
);

    state_t              state_q, state_d;
    logic                gnt_q, we_q, last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   cpu_rdata_q, uart_rdata_q;

    logic                grant_valid, grant_id, sel_we;
    logic [NUM_REGS-1:0] addr_dec;
    logic                in_range, ro_hit, ack_any;
    logic [DATA_W-1:0]   rd_sample;

    rr_arbiter_2 u_rr (
        .req         ({uart_req, cpu_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we = (grant_id == GNT_UART) ? uart_we : cpu_we;

    // State register plus the transaction latch and per-requester read-data holders.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= GNT_CPU;
            last_grant_q <= GNT_UART;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            uart_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && grant_valid) begin
                gnt_q        <= grant_id;
                last_grant_q <= grant_id;
                we_q         <= sel_we;
                addr_q       <= (grant_id == GNT_UART) ? uart_addr  : cpu_addr;
                wdata_q      <= (grant_id == GNT_UART) ? uart_wdata : cpu_wdata;
            end
            if (state_q == ST_READ) begin
                if (gnt_q == GNT_CPU) begin
                    cpu_rdata_q <= rd_sample;
                end else begin
                    uart_rdata_q <= rd_sample;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_valid) state_d = sel_we ? ST_WRITE : ST_READ;
            ST_WRITE: state_d = ST_TURN;
            ST_READ:  state_d = ST_TURN;
            ST_TURN:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Register-select decode; an out-of-range index matches no bit, so it strobes nothing.
    always_comb begin
        addr_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_dec[i] = (addr_q == ADDR_W'(i));
        end
    end

    assign in_range  = |addr_dec;
    assign rd_sample = in_range ? reg_q : '0;

`ifdef MMIO_ARB_ERR_EN
    // Only CPU writes are policed against the read-only mask.
    assign ro_hit = we_q && (gnt_q == GNT_CPU) && |(addr_dec & RO_MASK);
`else
    assign ro_hit = 1'b0;
`endif

    // Outputs decode from registered state only, so no req-to-strobe combinational path exists.
    always_comb begin
        reg_enable = '0;
        reg_oe     = '0;
        ack_any    = 1'b0;
        case (state_q)
            ST_WRITE: begin
                reg_enable = ro_hit ? '0 : addr_dec;
                ack_any    = 1'b1;
            end
            ST_READ:  reg_oe  = addr_dec;
            ST_TURN:  ack_any = ~we_q;      // read ack lands in the dead cycle after OE
            default:  ack_any = 1'b0;
        endcase
    end

    assign cpu_ack    = ack_any && (gnt_q == GNT_CPU);
    assign uart_ack   = ack_any && (gnt_q == GNT_UART);
    // reg_d is only qualified by reg_enable; leaving it unmuxed keeps it a plain register output.
    assign reg_d      = wdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign uart_rdata = uart_rdata_q;

`ifdef MMIO_ARB_ERR_EN
    assign cpu_err  = cpu_ack  && (!in_range || ro_hit);
    assign uart_err = uart_ack && (!in_range || ro_hit);
`endif

endmodule

// File: tb/tb_mmio_reg_arbiter.sv
// Directed bench for mmio_reg_arbiter: vector table of CPU accesses plus reset, round-robin and range sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_mmio_reg_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, uart_req = 1'b0, uart_we = 1'b0;
    logic [1:0]  cpu_addr = '0, uart_addr = '0;
    logic [31:0] cpu_wdata = '0, uart_wdata = '0;
    logic        cpu_ack, uart_ack;
    logic [31:0] cpu_rdata, uart_rdata, reg_d, reg_q;
    logic [3:0]  reg_enable, reg_oe;

    logic        cpu_ack3, uart_ack3;
    logic [31:0] cpu_rdata3, uart_rdata3, reg_d3;
    logic [2:0]  reg_enable3, reg_oe3;
    logic [31:0] reg_q3 = 32'hFFFF_FFFF;

`ifdef MMIO_ARB_ERR_EN
    logic cpu_err, uart_err, cpu_err3, uart_err3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mmio_reg_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_ack(uart_ack), .uart_rdata(uart_rdata),
`ifdef MMIO_ARB_ERR_EN
        .cpu_err(cpu_err), .uart_err(uart_err),
`endif
        .reg_enable(reg_enable), .reg_oe(reg_oe), .reg_d(reg_d), .reg_q(reg_q)
    );

    // Three-register instance so index 3 is out of range; its read bus floats high.
    mmio_reg_arbiter #(.NUM_REGS(3)) dut3 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_ack(uart_ack3), .uart_rdata(uart_rdata3),
`ifdef MMIO_ARB_ERR_EN
        .cpu_err(cpu_err3), .uart_err(uart_err3),
`endif
        .reg_enable(reg_enable3), .reg_oe(reg_oe3), .reg_d(reg_d3), .reg_q(reg_q3)
    );

    // Register bank model for the main instance; reg_q can be overridden to a fixed value.
    logic [31:0] bank [4] = '{default: 32'h0};
    logic        q_force_en = 1'b0;
    logic [31:0] q_force_val = '0;

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) if (reg_enable[i]) bank[i] <= reg_d;
    end

    always_comb begin
        reg_q = '0;
        if (q_force_en) reg_q = q_force_val;
        else for (int i = 0; i < 4; i++) if (reg_oe[i]) reg_q = bank[i];
    end

    // Bus-safety monitor: counts violations; the main flow compares the count at the end.
    int   viol = 0;
    int   mon_samples = 0;
    logic prev_oe = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            mon_samples++;
            if ($countones(reg_oe) > 1) begin
                viol++; $display("FAIL oe_onehot: reg_oe=%b required at most one bit", reg_oe);
            end
            if ((|reg_oe) && (|reg_enable)) begin
                viol++; $display("FAIL oe_vs_en: reg_oe=%b reg_enable=%b required not both", reg_oe, reg_enable);
            end
            if (prev_oe && (|reg_oe)) begin
                viol++; $display("FAIL oe_back2back: reg_oe=%b after OE cycle, required 0", reg_oe);
            end
            prev_oe = |reg_oe;
        end else begin
            prev_oe = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    // One access on the main instance. Called and returns at a negedge; waits are bounded to 8 cycles.
    task automatic txn(input logic who, input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [3:0] strb, output int strb_cycles,
                       output logic [31:0] rdata, output logic [31:0] dval, output int other_acks);
        logic ack, oth;
        if (who) begin uart_req = 1; uart_we = we; uart_addr = addr; uart_wdata = wdata; end
        else     begin cpu_req  = 1; cpu_we  = we; cpu_addr  = addr; cpu_wdata  = wdata; end
        lat = 0; strb = '0; strb_cycles = 0; rdata = '0; dval = '0; other_acks = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (|(reg_enable | reg_oe)) begin
                strb |= reg_enable | reg_oe;
                strb_cycles++;
                if (|reg_enable) dval = reg_d;
            end
            ack = who ? uart_ack : cpu_ack;
            oth = who ? cpu_ack : uart_ack;
            if (oth) other_acks++;
            if (ack && lat == 0) begin
                lat = k;
                rdata = who ? uart_rdata : cpu_rdata;
                cpu_req = 0; uart_req = 0;
            end
            if (lat != 0 && k >= lat + 2) break;
        end
        cpu_req = 0; uart_req = 0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          lat, sc, oth, lat3;
        logic [3:0]  strb;
        logic [2:0]  strb3;
        logic [31:0] rd, dv, rd3;
        logic        err3_seen;

        vecs[0] = '{1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0100, 32'h0};
        vecs[1] = '{1'b0, 2'd2, 32'h0,         4'b0100, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 2'd0, 32'h1234_5678, 4'b0001, 32'h0};
        vecs[3] = '{1'b1, 2'd3, 32'hCAFE_F00D, 4'b1000, 32'h0};
        vecs[4] = '{1'b0, 2'd0, 32'h0,         4'b0001, 32'h1234_5678};
        vecs[5] = '{1'b0, 2'd1, 32'h0,         4'b0010, 32'h0};
        vecs[6] = '{1'b0, 2'd3, 32'h0,         4'b1000, 32'hCAFE_F00D};

        // Reset state.
        @(negedge clock); @(negedge clock);
        check("rst_strobes", {24'h0, reg_enable, reg_oe}, 32'h0);
        check("rst_reg_d", reg_d, 32'h0);
        check("rst_acks", {30'h0, cpu_ack, uart_ack}, 32'h0);
        check("rst_rdata", cpu_rdata | uart_rdata, 32'h0);
        reset = 1;

        // Reset landing in the middle of a read.
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 2'd1;
        @(negedge clock);
        check("midrd_oe_before", {28'h0, reg_oe}, 32'h2);
        #2 reset = 0;
        #1 check("midrd_oe_async", {28'h0, reg_oe}, 32'h0);
        cpu_req = 0;
        @(negedge clock);
        check("midrd_no_ack", {31'h0, cpu_ack}, 32'h0);
        reset = 1;
        txn(1'b0, 1'b0, 2'd1, 32'h0, lat, strb, sc, rd, dv, oth);
        check("midrd_retry_lat", 32'(lat), 32'd2);
        check("midrd_retry_rdata", rd, 32'h0);

        // Vector table of CPU accesses.
        for (int v = 0; v < 7; v++) begin
            txn(1'b0, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, strb, sc, rd, dv, oth);
            check($sformatf("vec%0d_lat", v), 32'(lat), vecs[v].we ? 32'd1 : 32'd2);
            check($sformatf("vec%0d_strobe", v), {28'h0, strb}, {28'h0, vecs[v].exp_strb});
            check($sformatf("vec%0d_strobe_cycles", v), 32'(sc), 32'd1);
            check($sformatf("vec%0d_uart_ack", v), 32'(oth), 32'd0);
            if (vecs[v].we) check($sformatf("vec%0d_reg_d", v), dv, vecs[v].wdata);
            else            check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
        end

        // UART read of a forced bus value while the CPU is idle.
        q_force_en = 1; q_force_val = 32'h0000_00A5;
        txn(1'b1, 1'b0, 2'd3, 32'h0, lat, strb, sc, rd, dv, oth);
        q_force_en = 0;
        check("uart_rd_lat", 32'(lat), 32'd2);
        check("uart_rd_rdata", rd, 32'h0000_00A5);
        check("uart_rd_oe", {28'h0, strb}, 32'h8);
        check("uart_rd_cpu_rdata_held", cpu_rdata, 32'hCAFE_F00D);

        // Both requesters reading continuously from a fresh reset: CPU, UART, CPU, UART.
        reset = 0; @(negedge clock); reset = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 2'd0;
        uart_req = 1; uart_we = 0; uart_addr = 2'd3;
        for (int k = 1; k <= 12; k++) begin
            logic [1:0] exp_acks;
            @(negedge clock);
            exp_acks = {(k == 5 || k == 11), (k == 2 || k == 8)};
            check($sformatf("rr_acks_c%0d", k), {30'h0, uart_ack, cpu_ack}, {30'h0, exp_acks});
            if (cpu_ack || uart_ack) check($sformatf("rr_turn_oe_c%0d", k), {28'h0, reg_oe}, 32'h0);
            if (cpu_ack)  check($sformatf("rr_cpu_rdata_c%0d", k), cpu_rdata, 32'h1234_5678);
            if (uart_ack) check($sformatf("rr_uart_rdata_c%0d", k), uart_rdata, 32'hCAFE_F00D);
        end
        cpu_req = 0; uart_req = 0;
        @(negedge clock);

        // Out-of-range index 3 on the three-register instance: write then read.
        for (int t = 0; t < 2; t++) begin
            cpu_req = 1; cpu_we = (t == 0); cpu_addr = 2'd3; cpu_wdata = 32'h5555_0000;
            lat3 = 0; strb3 = '0; rd3 = 32'hBAD0_BAD0; err3_seen = 0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clock);
                strb3 |= reg_enable3 | reg_oe3;
                if (cpu_ack3 && lat3 == 0) begin
                    lat3 = k; rd3 = cpu_rdata3;
`ifdef MMIO_ARB_ERR_EN
                    err3_seen = cpu_err3;
`endif
                    cpu_req = 0;
                end
                if (lat3 != 0 && k >= lat3 + 2) break;
            end
            cpu_req = 0;
            check($sformatf("oor%0d_lat", t), 32'(lat3), (t == 0) ? 32'd1 : 32'd2);
            check($sformatf("oor%0d_no_strobe", t), {29'h0, strb3}, 32'h0);
            if (t == 1) check("oor_rdata_zero", rd3, 32'h0);
`ifdef MMIO_ARB_ERR_EN
            check($sformatf("oor%0d_err", t), {31'h0, err3_seen}, 32'h1);
`endif
        end

        // Random traffic for the bus-safety monitor.
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            cpu_req  = 1'($urandom_range(0, 1)); cpu_we  = 1'($urandom_range(0, 1));
            cpu_addr = 2'($urandom_range(0, 3)); cpu_wdata = $urandom;
            uart_req = 1'($urandom_range(0, 1)); uart_we = 1'($urandom_range(0, 1));
            uart_addr = 2'($urandom_range(0, 3)); uart_wdata = $urandom;
        end
        cpu_req = 0; uart_req = 0;
        repeat (4) @(negedge clock);

        check("bus_invariants", 32'(viol), 32'd0);
        check("monitor_active", {31'h0, mon_samples > 300}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
